// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control path and the multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic        mul;
    logic        div;
    logic        unsigned_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mul, div, unsigned_op, op_a, op_b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mul, div, unsigned_op, op_a, op_b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO and services MTHI/MTLO.
// Latency: accept edge + 32 iteration edges + 1 fixup edge; done pulses the cycle after.
// Backpressure: busy stalls control; start/mthi/mtlo are dropped while busy.
module muldiv_unit (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIXUP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] dvd_q, dvd_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        idle;
    logic        accept_mul, accept_div;
    logic        sign_a, sign_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // |0x80000000| stays 0x80000000, which the unsigned datapath handles as-is.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign idle       = (state_q == ST_IDLE);
    assign accept_mul = idle && bus.start && bus.mul && !bus.div;
    assign accept_div = idle && bus.start && bus.div && !bus.mul;
    assign sign_a     = !bus.unsigned_op && bus.op_a[31];
    assign sign_b     = !bus.unsigned_op && bus.op_b[31];
    assign abs_a      = magnitude(bus.op_a, sign_a);
    assign abs_b      = magnitude(bus.op_b, sign_b);

    // Multiply keeps {partial product, remaining multiplier} in acc; divide keeps {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
    assign div_shift = acc_q[63:31];
    assign div_diff  = div_shift - {1'b0, mag_q};
    assign div_ge    = (div_shift >= {1'b0, mag_q});

    assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = magnitude(acc_q[31:0], neg_res_q);
    assign rem_fix  = magnitude(acc_q[63:32], neg_rem_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        dvd_d     = dvd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_mul || accept_div) begin
                    state_d   = accept_mul ? ST_MUL : ST_DIV;
                    cnt_d     = 5'd0;
                    acc_d     = {32'd0, accept_mul ? abs_b : abs_a};
                    mag_d     = accept_mul ? abs_a : abs_b;
                    dvd_d     = bus.op_a;
                    is_div_d  = accept_div;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    dz_d      = (bus.op_b == 32'd0);
                end else if (!bus.start) begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_FIXUP;
            end
            ST_DIV: begin
                acc_d = div_ge ? {div_diff[31:0], acc_q[30:0], 1'b1}
                               : {div_shift[31:0], acc_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (dz_q) begin
                    hi_d = dvd_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            mag_q     <= 32'd0;
            dvd_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            dvd_q     <= dvd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = !idle;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
